// File: rtl/a_io_l3_m_axi_pkg.sv
// Shared encodings for the serialize_A m_axi read responder.
// Holds the AXI response and burst-type codes and the responder FSM state type.
package a_io_l3_m_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/a_io_l3_in_serialize_a_m_axi_rd_mem.sv
// Word-addressed backing store for the read responder.
// Ports:
//   clk    - clock; writes occur on the rising edge
//   we     - write enable
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address (combinational read)
//   rdata  - read data; shows pre-write contents in the cycle of a same-word write
module a_io_l3_in_serialize_a_m_axi_rd_mem
  import a_io_l3_m_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/a_io_l3_in_serialize_a_m_axi_rd_responder.sv
// AXI4 read responder serving the serialize_A m_axi master from a local
// word-addressed memory that is preloaded through a backdoor write port.
// One burst outstanding at a time; FIXED and INCR bursts are served, any
// other burst type returns SLVERR on every beat. Out-of-range words return
// SLVERR with zero data. The burst always runs its full arlen+1 beats.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   arvalid/arready/araddr/
//   arid/arlen/arburst          - read address channel (arready registered)
//   rvalid/rready/rdata/rid/
//   rresp/rlast                 - read data channel (all outputs registered)
//   mem_we/mem_waddr/mem_wdata  - backdoor memory write port
module a_io_l3_in_serialize_a_m_axi_rd_responder
  import a_io_l3_m_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [7:0]                   arlen,
  input  logic [1:0]                   arburst,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int MAW   = $clog2(MEM_DEPTH);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [7:0]            len_p0;
  logic [1:0]            burst_p0;
  logic [7:0]            beat_p0;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            cur_burst;
  logic [7:0]            cur_beat;
  logic [7:0]            cur_len;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  beat_err;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  load;

  // The first beat is loaded on the AR handshake edge itself, straight from
  // the AR channel; later beats come from the captured burst context.
  always_comb begin
    cur_addr  = addr_p0;
    cur_burst = burst_p0;
    cur_beat  = beat_p0;
    cur_len   = len_p0;
    if (state == ST_IDLE) begin
      cur_addr  = araddr;
      cur_burst = arburst;
      cur_beat  = 8'd0;
      cur_len   = arlen;
    end
  end

  assign word_idx  = cur_addr >> SH;
  // Anything other than FIXED/INCR (WRAP, reserved) errors every beat.
  assign beat_err  = !((cur_burst == BURST_FIXED) || (cur_burst == BURST_INCR))
                     || (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
  assign next_addr = (cur_burst == BURST_INCR) ? cur_addr + ADDR_WIDTH'(BYTES) : cur_addr;

  assign ar_hs = (state == ST_IDLE) && arvalid && arready;
  assign r_hs  = rvalid && rready;
  // Once the last beat sits in the output register, nothing more is loaded.
  assign load  = ar_hs ||
                 ((state == ST_BURST) && (!rvalid || rready) && !(rvalid && rlast));

  a_io_l3_in_serialize_a_m_axi_rd_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (word_idx[MAW-1:0]),
    .rdata (mem_rdata)
  );

  // ---- p0: burst context (address, length, type, next beat index) ----
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      len_p0   <= arlen;
      burst_p0 <= arburst;
    end
    if (load) begin
      addr_p0 <= next_addr;
      beat_p0 <= cur_beat + 8'd1;
    end
  end

  // ---- R output register and FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      if (load) begin
        rvalid <= 1'b1;
        rdata  <= beat_err ? '0 : mem_rdata;
        rresp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
        rlast  <= (cur_beat == cur_len);
      end else if (r_hs) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            state   <= ST_BURST;
            arready <= 1'b0;
            rid     <= arid;
          end else begin
            arready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (r_hs && rlast) begin
            state   <= ST_IDLE;
            arready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
